// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider with valid/ready handshakes
// Optional macro SEQ_DIVIDER_ZERO_BYPASS_EN: divide-by-zero finishes on the accept edge.
module seq_divider #(
  parameter int DATAWIDTH   = 4,
  parameter int INSTANCE_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [DATAWIDTH-1:0] Q,
  output logic [DATAWIDTH-1:0] R,
  output logic                 div_by_zero
);

  localparam int CW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;

  generate
    if (DATAWIDTH < 2 || DATAWIDTH > 32 || INSTANCE_ID < 0) begin : g_bad_param
      $error("seq_divider: illegal parameter value");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [DATAWIDTH-1:0]  dividend;
  logic [DATAWIDTH-1:0]  divisor;
  logic [DATAWIDTH:0]    prem;
  logic [DATAWIDTH-1:0]  quot;
  logic [CW-1:0]         cnt;

  // Trial subtraction carries one extra bit so its MSB is a true sign bit.
  logic [DATAWIDTH+1:0]  shifted;
  logic [DATAWIDTH+1:0]  trial;
  logic                  trial_neg;

  always_comb begin
    shifted   = {prem, dividend[DATAWIDTH-1]};
    trial     = shifted - {2'b00, divisor};
    trial_neg = trial[DATAWIDTH+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      i_ready     <= 1'b1;
      o_valid     <= 1'b0;
      dividend    <= '0;
      divisor     <= '0;
      prem        <= '0;
      quot        <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            dividend    <= A;
            divisor     <= B;
            div_by_zero <= (B == '0);
            prem        <= '0;
            quot        <= '0;
            cnt         <= CW'(DATAWIDTH - 1);
            i_ready     <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
            if (B == '0) begin
              quot    <= '1;
              prem    <= {1'b0, A};
              o_valid <= 1'b1;
              state   <= DONE;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end

        BUSY: begin
          dividend <= {dividend[DATAWIDTH-2:0], 1'b0};
          if (trial_neg) begin
            prem <= shifted[DATAWIDTH:0];
            quot <= {quot[DATAWIDTH-2:0], 1'b0};
          end else begin
            prem <= trial[DATAWIDTH:0];
            quot <= {quot[DATAWIDTH-2:0], 1'b1};
          end
          if (cnt == '0) begin
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          // Result registers are untouched here, so they hold under backpressure.
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          i_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Q = quot;
  assign R = prem[DATAWIDTH-1:0];

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (DATAWIDTH=4)
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       i_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       o_valid;
  logic       o_ready;
  logic [3:0] q;
  logic [3:0] r;
  logic       dz;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 4;
`endif

  seq_divider #(.DATAWIDTH(4), .INSTANCE_ID(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .A           (a),
    .B           (b),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .Q           (q),
    .R           (r),
    .div_by_zero (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Offer one operand pair, measure latency from the accept edge, hold off the
  // consumer for 'hold' cycles, then complete the handshake.
  task automatic run_op(input logic [3:0] a_in, input logic [3:0] b_in,
                        input logic [3:0] eq, input logic [3:0] er, input logic edz,
                        input int lat, input int hold, input bit intrude);
    int k;
    @(posedge clk); #1;
    chk("ready_idle", i_ready, 1);
    i_valid = 1'b1; a = a_in; b = b_in;
    @(posedge clk); #1;
    i_valid = 1'b0; a = 4'd0; b = 4'd0;
    for (k = 1; k <= 20; k++) begin
      if (intrude) begin
        i_valid = k[0]; a = 4'd1; b = 4'd1;
      end
      @(posedge clk); #1;
      chk("ready_busy", i_ready, 0);
      if (o_valid) break;
    end
    i_valid = 1'b0;
    chk("latency", k, lat);
    chk("q", q, eq);
    chk("r", r, er);
    chk("dz", dz, edz);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", o_valid, 1);
      chk("hold_q", q, eq);
      chk("hold_r", r, er);
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    chk("valid_after_hs", o_valid, 0);
    chk("ready_after_hs", i_ready, 1);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; a = 4'd0; b = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", i_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_dz", dz, 0);
    rst = 1'b0;

    run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, 0, 1'b0);
    run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, 0, 1'b0);
    run_op(4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 4, 0, 1'b0);
    run_op(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, ZERO_LAT, 0, 1'b0);
    run_op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 4, 10, 1'b0);
    run_op(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 4, 0, 1'b1);
    run_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4, 0, 1'b0);
    run_op(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 4, 0, 1'b0);

    // Reset on edge 2 of an operation abandons it.
    @(posedge clk); #1;
    i_valid = 1'b1; a = 4'd14; b = 4'd5;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", i_ready, 1);
    chk("midrst_q", q, 0);
    chk("midrst_r", r, 0);
    run_op(4'd14, 4'd5, 4'd2, 4'd4, 1'b0, 4, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
